mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, waitrequest-style memory between the processor's instruction-fetch port and its data (load/store) port.
- Registered grant FSM: data side has priority, with a starvation counter that guarantees forward progress for fetch.
- Sits between the processor and the unified memory. Each processor port sees its own waitrequest, and the processor stalls on it.

Parameters:
- WORD_SIZE, 16, width of addresses and data words.
- MAX_STARVE, 4, consecutive cycles fetch may wait while requesting before it gets priority over data (range 1..255).
- STARVE_BITS, $clog2(MAX_STARVE+1), width of the starvation counter (derived, do not override).

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- InstrAddr  in  WORD_SIZE  fetch address.
- InstrRead  in  1  fetch request.
- InstrDataIn  out  WORD_SIZE  fetch read data; valid when InstrRead=1 and InstrWaitreq=0.
- InstrWaitreq  out  1  fetch stall.
- DataAddr  in  WORD_SIZE  load/store address.
- DataOut  in  WORD_SIZE  store data.
- ReadData  in  1  load request.
- WriteData  in  1  store request.
- DataIn  out  WORD_SIZE  load data; valid when ReadData=1 and DataWaitreq=0.
- DataWaitreq  out  1  data stall.
- MemAddr  out  WORD_SIZE  memory address.
- MemWriteData  out  WORD_SIZE  memory write data.
- MemRead  out  1  memory read command.
- MemWrite  out  1  memory write command.
- MemReadData  in  WORD_SIZE  memory read data; valid in the accept cycle.
- MemWaitreq  in  1  memory not ready; a command is accepted in any cycle with (MemRead|MemWrite)=1 and MemWaitreq=0.

Behaviour:
- Request definitions: reqI = InstrRead; reqD = ReadData|WriteData.
- ReadData and WriteData both high is treated as a write.
- Requester protocol: address and data are held stable while the port's waitreq is high. The bench checks this; the arbiter does not enforce it.
- FSM states IDLE, OWN_I, OWN_D (registered).
  - In IDLE no memory command is driven.
  - In OWN_x, the memory signals are a combinational mux of requester x's signals, gated by reqx. Command is driven only while reqx=1.
- Arbitration function arb(i,d):
  - result OWN_D if d=1 and not (i=1 and starve>=MAX_STARVE);
  - else OWN_I if i=1;
  - else IDLE.
- Transitions:
  - IDLE -> arb(reqI, reqD).
  - OWN_x with reqx=1 and MemWaitreq=1: stay.
  - OWN_x with accept: arbitrate with the owner's request masked, i.e. OWN_I -> arb(0, reqD); OWN_D -> arb(reqI, 0).
  - OWN_x with reqx=0 (request withdrawn, e.g. flush): arb(reqI, reqD) with no masking; no memory command issued that cycle.
- Minimum latency: request at cycle t (IDLE) -> command at t+1 -> if MemWaitreq=0, waitreq low at t+1. Back-to-back alternating I/D accesses complete one per cycle.
- Waitreq outputs:
  - InstrWaitreq = reqI and not (state==OWN_I and MemWaitreq==0).
  - DataWaitreq = reqD and not (state==OWN_D and MemWaitreq==0).
  - No request means waitreq is low.
- Read data: InstrDataIn = DataIn = MemReadData at all times; qualified by the port's waitreq.
- Starvation counter, updated each cycle:
  - cleared on a fetch accept;
  - else incremented (saturating at MAX_STARVE) while reqI=1;
  - else cleared when reqI=0.
- Reset (asynchronous, any cycle, including mid-transaction):
  - state -> IDLE, starve -> 0.
  - While Reset is high: MemRead=MemWrite=0, MemAddr=MemWriteData=0, InstrWaitreq=InstrRead, DataWaitreq=reqD.
  - The transaction in flight is dropped; requesters re-present after reset.
- Simultaneous reqI and reqD in IDLE with starve<MAX_STARVE: data wins.
- No combinational path from MemWaitreq to MemRead/MemWrite.

Test Plan:
- Single fetch: InstrRead=1, InstrAddr=0x0010 at t0, MemWaitreq=0, MemReadData=0xA5A5 -> MemRead=1, MemAddr=0x0010 at t1; InstrWaitreq=1 at t0, 0 at t1; InstrDataIn=0xA5A5 at t1.
- Simultaneous requests: InstrRead=1 and ReadData=1 (DataAddr=0x0200) at t0 -> OWN_D at t1 (MemAddr=0x0200), OWN_I at t2 (MemAddr=InstrAddr); both waitreqs low in their own grant cycle only.
- Starvation: reqD held continuously (a new address each accept) with reqI=1, MAX_STARVE=4 -> fetch granted no later than the 6th cycle after t0; counter returns to 0 after the fetch accept.
- Memory stall: store to 0x0300 with data 0xBEEF and MemWaitreq=1 for 3 cycles -> MemWrite, MemAddr and MemWriteData held stable; DataWaitreq=1 for those 3 cycles; exactly one accept.
- Withdrawal and reset: in OWN_I with MemWaitreq=1, drop InstrRead -> MemRead=0 the same cycle, state -> IDLE (or OWN_D if reqD) next cycle. Separately, assert Reset mid-OWN_D -> MemWrite=0 immediately, state IDLE after reset release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Processor fetch/data ports and unified memory port bundled for the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] instr_addr;
  logic                 instr_read;
  logic [WORD_SIZE-1:0] instr_data_in;
  logic                 instr_waitreq;
  logic [WORD_SIZE-1:0] data_addr;
  logic [WORD_SIZE-1:0] data_out;
  logic                 read_data;
  logic                 write_data;
  logic [WORD_SIZE-1:0] data_in;
  logic                 data_waitreq;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_write_data;
  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_read_data;
  logic                 mem_waitreq;

  modport slave (
    input  instr_addr, instr_read, data_addr, data_out, read_data, write_data,
    input  mem_read_data, mem_waitreq,
    output instr_data_in, instr_waitreq, data_in, data_waitreq,
    output mem_addr, mem_write_data, mem_read, mem_write
  );

  modport master (
    output instr_addr, instr_read, data_addr, data_out, read_data, write_data,
    output mem_read_data, mem_waitreq,
    input  instr_data_in, instr_waitreq, data_in, data_waitreq,
    input  mem_addr, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one waitrequest-style memory between fetch and data ports.
// Data has priority; a starvation counter forces a fetch grant after MAX_STARVE waits.
module mem_port_arbiter #(
  parameter int  WORD_SIZE   = 16,
  parameter int  MAX_STARVE  = 4,
  localparam int STARVE_BITS = $clog2(MAX_STARVE + 1)
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  localparam logic [STARVE_BITS-1:0] STARVE_LIMIT = STARVE_BITS'(MAX_STARVE);
  localparam logic [STARVE_BITS-1:0] STARVE_ONE   = STARVE_BITS'(1);

  state_t                 state_r;
  logic [STARVE_BITS-1:0] starve_r;

  logic                 req_i_s;
  logic                 req_d_s;
  logic                 cmd_i_s;
  logic                 cmd_d_s;
  logic                 starved_s;
  logic                 fetch_accept_s;
  logic [WORD_SIZE-1:0] mem_addr_s;
  logic [WORD_SIZE-1:0] mem_wdata_s;
  logic                 mem_read_s;
  logic                 mem_write_s;

  function automatic state_t arb(input logic i, input logic d, input logic starved);
    if (d && !(i && starved)) begin
      arb = OWN_D;
    end else if (i) begin
      arb = OWN_I;
    end else begin
      arb = IDLE;
    end
  endfunction

  assign req_i_s        = bus.instr_read;
  assign req_d_s        = bus.read_data | bus.write_data;
  assign cmd_i_s        = (state_r == OWN_I) && req_i_s;
  assign cmd_d_s        = (state_r == OWN_D) && req_d_s;
  assign starved_s      = (starve_r >= STARVE_LIMIT);
  assign fetch_accept_s = cmd_i_s && !bus.mem_waitreq;

  // Memory command mux: owner's signals only while the owner still requests.
  always_comb begin
    mem_addr_s  = {WORD_SIZE{1'b0}};
    mem_wdata_s = {WORD_SIZE{1'b0}};
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    if (cmd_i_s) begin
      mem_addr_s = bus.instr_addr;
      mem_read_s = 1'b1;
    end else if (cmd_d_s) begin
      mem_addr_s  = bus.data_addr;
      mem_wdata_s = bus.data_out;
      mem_write_s = bus.write_data;
      mem_read_s  = !bus.write_data;
    end else begin
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
    end
  end

  // Grant FSM and starvation counter; the owner is masked out of re-arbitration on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      starve_r <= {STARVE_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: state_r <= arb(req_i_s, req_d_s, starved_s);
        OWN_I: begin
          if (!req_i_s) begin
            state_r <= arb(req_i_s, req_d_s, starved_s);
          end else if (bus.mem_waitreq) begin
            state_r <= OWN_I;
          end else begin
            state_r <= arb(1'b0, req_d_s, starved_s);
          end
        end
        OWN_D: begin
          if (!req_d_s) begin
            state_r <= arb(req_i_s, req_d_s, starved_s);
          end else if (bus.mem_waitreq) begin
            state_r <= OWN_D;
          end else begin
            state_r <= arb(req_i_s, 1'b0, starved_s);
          end
        end
        default: state_r <= IDLE;
      endcase

      if (fetch_accept_s) begin
        starve_r <= {STARVE_BITS{1'b0}};
      end else if (req_i_s) begin
        starve_r <= starved_s ? STARVE_LIMIT : (starve_r + STARVE_ONE);
      end else begin
        starve_r <= {STARVE_BITS{1'b0}};
      end
    end
  end

  assign bus.mem_addr       = mem_addr_s;
  assign bus.mem_write_data = mem_wdata_s;
  assign bus.mem_read       = mem_read_s;
  assign bus.mem_write      = mem_write_s;
  assign bus.instr_waitreq  = req_i_s && !((state_r == OWN_I) && !bus.mem_waitreq);
  assign bus.data_waitreq   = req_d_s && !((state_r == OWN_D) && !bus.mem_waitreq);
  assign bus.instr_data_in  = bus.mem_read_data;
  assign bus.data_in        = bus.mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against an owner/starve reference model.
module tb_mem_port_arbiter;
  localparam int WS = 16;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WORD_SIZE(WS)) bus ();
  mem_port_arbiter #(.WORD_SIZE(WS), .MAX_STARVE(MS)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int m_owner = 0;   // 0 none, 1 fetch, 2 data
  int m_starve = 0;
  bit e_iw, e_dw;

  task automatic chk(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int arb_ref(bit i, bit d);
    if (d && !(i && m_starve >= MS)) return 2;
    if (i) return 1;
    return 0;
  endfunction

  task automatic model_check();
    bit ri, rq, ci, cd, er, ewr;
    logic [WS-1:0] ea, ew;
    ri  = bus.instr_read;
    rq  = bus.read_data | bus.write_data;
    ci  = (m_owner == 1) && ri;
    cd  = (m_owner == 2) && rq;
    er  = ci || (cd && !bus.write_data);
    ewr = cd && bus.write_data;
    ea  = ci ? bus.instr_addr : (cd ? bus.data_addr : 16'h0000);
    ew  = cd && !ci ? bus.data_out : 16'h0000;
    e_iw = ri && !((m_owner == 1) && !bus.mem_waitreq);
    e_dw = rq && !((m_owner == 2) && !bus.mem_waitreq);
    chk("mem_read", 16'(bus.mem_read), 16'(er));
    chk("mem_write", 16'(bus.mem_write), 16'(ewr));
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wdata", bus.mem_write_data, ew);
    chk("instr_waitreq", 16'(bus.instr_waitreq), 16'(e_iw));
    chk("data_waitreq", 16'(bus.data_waitreq), 16'(e_dw));
    chk("instr_data_in", bus.instr_data_in, bus.mem_read_data);
    chk("data_in", bus.data_in, bus.mem_read_data);
  endtask

  task automatic settle();
    #3;
    model_check();
  endtask

  task automatic tick();
    int nxt, ns;
    bit ri, rq, mw;
    ri = bus.instr_read;
    rq = bus.read_data | bus.write_data;
    mw = bus.mem_waitreq;
    if (m_owner == 0) nxt = arb_ref(ri, rq);
    else if (m_owner == 1) nxt = !ri ? arb_ref(ri, rq) : (mw ? 1 : arb_ref(1'b0, rq));
    else nxt = !rq ? arb_ref(ri, rq) : (mw ? 2 : arb_ref(ri, 1'b0));
    if (m_owner == 1 && ri && !mw) ns = 0;
    else if (ri) ns = (m_starve < MS) ? m_starve + 1 : MS;
    else ns = 0;
    @(posedge clk);
    if (rst) begin
      m_owner = 0;
      m_starve = 0;
    end else begin
      m_owner = nxt;
      m_starve = ns;
    end
    #1;
  endtask

  task automatic drive(input bit ir, input logic [WS-1:0] ia, input bit rd, input bit wr,
                       input logic [WS-1:0] da, input logic [WS-1:0] dout, input bit mw,
                       input logic [WS-1:0] mrd);
    bus.instr_read    = ir;
    bus.instr_addr    = ia;
    bus.read_data     = rd;
    bus.write_data    = wr;
    bus.data_addr     = da;
    bus.data_out      = dout;
    bus.mem_waitreq   = mw;
    bus.mem_read_data = mrd;
  endtask

  initial begin
    int grant, accepts;
    bit hold_i, hold_d;

    // Reset: no command, waitreqs follow requests.
    rst = 1'b1;
    drive(1'b1, 16'h0011, 1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0, 16'h0000);
    #2;
    model_check();
    chk("rst_mem_read", 16'(bus.mem_read), 16'h0000);
    chk("rst_instr_waitreq", 16'(bus.instr_waitreq), 16'h0001);
    chk("rst_data_waitreq", 16'(bus.data_waitreq), 16'h0001);
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    settle(); tick();

    // Single fetch.
    drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA5A5);
    settle();
    chk("fetch_t0_waitreq", 16'(bus.instr_waitreq), 16'h0001);
    tick(); settle();
    chk("fetch_t1_read", 16'(bus.mem_read), 16'h0001);
    chk("fetch_t1_addr", bus.mem_addr, 16'h0010);
    chk("fetch_t1_waitreq", 16'(bus.instr_waitreq), 16'h0000);
    chk("fetch_t1_data", bus.instr_data_in, 16'hA5A5);
    tick();
    bus.instr_read = 1'b0;
    settle(); tick();

    // Simultaneous requests: data first, then fetch.
    drive(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 16'h1111);
    settle(); tick(); settle();
    chk("simul_t1_addr", bus.mem_addr, 16'h0200);
    chk("simul_t1_dwait", 16'(bus.data_waitreq), 16'h0000);
    chk("simul_t1_iwait", 16'(bus.instr_waitreq), 16'h0001);
    tick();
    bus.read_data = 1'b0;
    settle();
    chk("simul_t2_addr", bus.mem_addr, 16'h0040);
    chk("simul_t2_iwait", 16'(bus.instr_waitreq), 16'h0000);
    tick();
    bus.instr_read = 1'b0;
    settle(); tick();

    // Starvation: continuous loads while fetching.
    drive(1'b1, 16'h0050, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 16'h2222);
    grant = -1;
    for (int k = 0; k < 8; k++) begin
      settle();
      hold_d = e_dw;
      if (grant < 0 && !bus.instr_waitreq) grant = k;
      tick();
      if (!hold_d) bus.data_addr = bus.data_addr + 16'h0001;
      if (grant == k) begin
        chk("starve_cleared", 16'(dut.starve_r), 16'h0000);
        bus.instr_read = 1'b0;
      end
    end
    chk("starve_grant_bound", 16'(grant >= 0 && grant <= 5), 16'h0001);
    bus.read_data = 1'b0;
    settle(); tick();

    // Memory stall on a store.
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0300, 16'hBEEF, 1'b1, 16'h0000);
    accepts = 0;
    for (int k = 0; k < 5; k++) begin
      bus.mem_waitreq = (k < 4);
      settle();
      if (k >= 1 && k <= 3) begin
        chk("stall_write", 16'(bus.mem_write), 16'h0001);
        chk("stall_addr", bus.mem_addr, 16'h0300);
        chk("stall_wdata", bus.mem_write_data, 16'hBEEF);
        chk("stall_dwait", 16'(bus.data_waitreq), 16'h0001);
      end
      if (bus.mem_write && !bus.mem_waitreq) accepts++;
      tick();
    end
    chk("stall_accepts", 16'(accepts), 16'h0001);
    bus.write_data = 1'b0;
    settle(); tick();

    // Fetch withdrawal while stalled, with a load waiting.
    drive(1'b1, 16'h0060, 1'b0, 1'b0, 16'h0500, 16'h0000, 1'b1, 16'h0000);
    settle(); tick(); settle();
    chk("wd_read_before", 16'(bus.mem_read), 16'h0001);
    tick();
    bus.instr_read = 1'b0;
    bus.read_data = 1'b1;
    settle();
    chk("wd_read_dropped", 16'(bus.mem_read), 16'h0000);
    tick();
    bus.mem_waitreq = 1'b0;
    settle();
    chk("wd_data_owner_addr", bus.mem_addr, 16'h0500);
    tick();
    bus.read_data = 1'b0;
    settle(); tick();

    // Reset in the middle of a stalled store.
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0700, 16'h1234, 1'b1, 16'h0000);
    settle(); tick(); settle();
    chk("rst_mid_write_before", 16'(bus.mem_write), 16'h0001);
    #1 rst = 1'b1;
    #1;
    m_owner = 0;
    m_starve = 0;
    model_check();
    chk("rst_mid_write_now", 16'(bus.mem_write), 16'h0000);
    tick();
    rst = 1'b0;
    settle();
    chk("rst_release_idle", 16'(bus.mem_write), 16'h0000);
    tick();
    bus.write_data = 1'b0;
    settle(); tick();

    // Randomized traffic under protocol: requests held while stalled.
    for (int n = 0; n < 500; n++) begin
      settle();
      hold_i = bus.instr_read && e_iw;
      hold_d = (bus.read_data || bus.write_data) && e_dw;
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1;
        m_owner = 0;
        m_starve = 0;
        model_check();
      end
      tick();
      rst = 1'b0;
      if (hold_i) begin
        if ($urandom_range(0, 29) == 0) bus.instr_read = 1'b0;
      end else begin
        bus.instr_read = ($urandom_range(0, 99) < 60);
        bus.instr_addr = 16'($urandom);
      end
      if (!hold_d) begin
        bus.read_data  = ($urandom_range(0, 99) < 40);
        bus.write_data = ($urandom_range(0, 99) < 30);
        bus.data_addr  = 16'($urandom);
        bus.data_out   = 16'($urandom);
      end
      bus.mem_waitreq   = ($urandom_range(0, 99) < 35);
      bus.mem_read_data = 16'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
